// File: rtl/multiplier_seq_if.sv
// Operand and product handshake bundle for multiplier_seq.
// The master drives the operands and out_ready; the slave is the multiplier.
interface multiplier_seq_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic               busy;

    modport master (
        output in_valid, in_signed, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product,
// fixed WIDTH-cycle latency, per-transaction signed/unsigned mode.
module multiplier_seq #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    multiplier_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q;
    logic            neg_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mult_q;
    logic [PW-1:0]   accum_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   out_p_q;
    logic            out_valid_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    accum_d;
    logic [PW-1:0]    prod_d;

    // Signed operands are reduced to magnitudes so the core is a plain unsigned
    // shift-add; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits WIDTH bits.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        mag_a   = (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
        mag_b   = (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
        accum_d = accum_q + (mult_q[0] ? (mcand_q << cnt_q) : '0);
        prod_d  = neg_q ? -accum_d : accum_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            mcand_q     <= '0;
            mult_q      <= '0;
            accum_q     <= '0;
            cnt_q       <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q <= {{WIDTH{1'b0}}, mag_a};
                        mult_q  <= mag_b;
                        neg_q   <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                        accum_q <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    accum_q <= accum_d;
                    mult_q  <= mult_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    // Last partial product is folded in directly on the final edge.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        out_p_q     <= prod_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq at WIDTH=4 (directed + random) and
// WIDTH=8 (random), scored against a plain-arithmetic product model.
module tb_multiplier_seq;
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst8_n = 1'b0;
    always #5 clk = ~clk;

    multiplier_seq_if #(.WIDTH(4)) bus4 ();
    multiplier_seq_if #(.WIDTH(8)) bus8 ();

    multiplier_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n),  .bus(bus4));
    multiplier_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

    typedef struct {
        logic [15:0] p;
        int          due;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t q4[$];
    exp_t q8[$];
    bit   shown4 = 0;
    bit   shown8 = 0;
    int   in4 = 0, out4 = 0, in8 = 0, out8 = 0;
    bit   done8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden product: interpret operands per mode, multiply, keep 2*w bits.
    function automatic logic [15:0] golden(input int w, input bit s,
                                           input logic [7:0] a, input logic [7:0] b);
        int ia, ib, p;
        ia = int'(a);
        ib = int'(b);
        if (s && a[w-1]) ia -= (1 << w);
        if (s && b[w-1]) ib -= (1 << w);
        p = ia * ib;
        return 16'(p & ((1 << (2 * w)) - 1));
    endfunction

    // Scoreboard for the WIDTH=4 instance, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in4 -= q4.size();
            q4.delete();
            shown4 = 0;
            check("rst_in_ready4",  32'(bus4.in_ready),  32'd1);
            check("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
            check("rst_out_p4",     32'(bus4.out_p),     32'd0);
            check("rst_busy4",      32'(bus4.busy),      32'd0);
        end else begin
            check("busy_vs_ready4", 32'(bus4.busy), 32'(!bus4.in_ready));
            if (q4.size() > 0 && !shown4 && cyc == q4[0].due)
                check("valid_on_time4", 32'(bus4.out_valid), 32'd1);
            if (bus4.out_valid) begin
                if (q4.size() == 0) begin
                    check("spurious_valid4", 32'(bus4.out_valid), 32'd0);
                end else begin
                    if (!shown4) check("latency4", 32'(cyc), 32'(q4[0].due));
                    shown4 = 1;
                    check("out_p4", 32'(bus4.out_p), 32'(q4[0].p));
                    check("in_ready_done4", 32'(bus4.in_ready), 32'd0);
                    if (bus4.out_ready) begin
                        void'(q4.pop_front());
                        shown4 = 0;
                        out4++;
                    end
                end
            end
            if (bus4.in_valid && bus4.in_ready) begin
                q4.push_back('{golden(4, bus4.in_signed, {4'b0, bus4.in_a}, {4'b0, bus4.in_b}),
                               cyc + 1 + 4});
                in4++;
            end
        end
    end

    // Scoreboard for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!rst8_n) begin
            in8 -= q8.size();
            q8.delete();
            shown8 = 0;
            check("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
        end else begin
            if (q8.size() > 0 && !shown8 && cyc == q8[0].due)
                check("valid_on_time8", 32'(bus8.out_valid), 32'd1);
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    check("spurious_valid8", 32'(bus8.out_valid), 32'd0);
                end else begin
                    if (!shown8) check("latency8", 32'(cyc), 32'(q8[0].due));
                    shown8 = 1;
                    check("out_p8", 32'(bus8.out_p), 32'(q8[0].p));
                    check("in_ready_done8", 32'(bus8.in_ready), 32'd0);
                    if (bus8.out_ready) begin
                        void'(q8.pop_front());
                        shown8 = 0;
                        out8++;
                    end
                end
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back('{golden(8, bus8.in_signed, bus8.in_a, bus8.in_b), cyc + 1 + 8});
                in8++;
            end
        end
    end

    // One directed transaction with a literal expected product and optional stall.
    task automatic op4(input bit s, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] lit, input int stall);
        int k;
        bus4.in_signed = s;
        bus4.in_a      = a;
        bus4.in_b      = b;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = (stall == 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus4.in_ready && k < 20);
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        bus4.in_a      = ~a;
        bus4.in_b      = a ^ b;
        bus4.in_signed = ~s;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus4.out_valid && k < 20);
        check("op_valid", 32'(bus4.out_valid), 32'd1);
        check("op_out_p", 32'(bus4.out_p), 32'(lit));
        repeat (stall) begin
            @(negedge clk);
            check("stall_out_p",    32'(bus4.out_p),     32'(lit));
            check("stall_in_ready", 32'(bus4.in_ready),  32'd0);
            check("stall_valid",    32'(bus4.out_valid), 32'd1);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            bus4.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("post_valid", 32'(bus4.out_valid), 32'd0);
        check("post_idle",  32'(bus4.in_ready),  32'd1);
    endtask

    task automatic drain4();
        int guard = 0;
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        while ((q4.size() > 0 || bus4.busy) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain4_idle", 32'(bus4.busy), 32'd0);
    endtask

    initial begin
        bus8.in_valid = 1'b0; bus8.in_signed = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
        bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst8_n = 1'b1;
        begin
            int guard = 0;
            while (in8 < 1000 && guard < 40000) begin
                @(posedge clk); #1;
                bus8.in_valid  = ($urandom_range(0, 3) != 0);
                bus8.in_signed = 1'($urandom_range(0, 1));
                bus8.in_a      = 8'($urandom);
                bus8.in_b      = 8'($urandom);
                bus8.out_ready = ($urandom_range(0, 2) != 0);
                guard++;
            end
            @(posedge clk); #1;
            bus8.in_valid  = 1'b0;
            bus8.out_ready = 1'b1;
            guard = 0;
            while ((q8.size() > 0 || bus8.busy) && guard < 100) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        done8 = 1;
    end

    initial begin
        bus4.in_valid = 1'b0; bus4.in_signed = 1'b0; bus4.in_a = '0; bus4.in_b = '0;
        bus4.out_ready = 1'b1;

        check("pin_model_s4",  32'(golden(4, 1'b1, 8'h0D, 8'h05)), 32'h00F1);
        check("pin_model_u8",  32'(golden(8, 1'b0, 8'hFF, 8'hFF)), 32'hFE01);
        check("pin_model_s8",  32'(golden(8, 1'b1, 8'h80, 8'h80)), 32'h4000);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        op4(1'b0, 4'd3,  4'd5,  8'd15,  0);
        op4(1'b0, 4'd15, 4'd15, 8'd225, 0);
        op4(1'b0, 4'd0,  4'd9,  8'd0,   0);
        op4(1'b1, 4'hD,  4'h5,  8'hF1,  0);
        op4(1'b1, 4'h8,  4'h8,  8'h40,  0);
        op4(1'b1, 4'h8,  4'h7,  8'hC8,  0);
        op4(1'b1, 4'h7,  4'hF,  8'hF9,  0);
        op4(1'b1, 4'h0,  4'h8,  8'h00,  0);
        op4(1'b0, 4'd6,  4'd7,  8'd42,  10);

        // Reset asserted on the second BUSY cycle discards the product.
        bus4.in_signed = 1'b0; bus4.in_a = 4'd6; bus4.in_b = 4'd7;
        bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_valid_after_rst", 32'(bus4.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        op4(1'b0, 4'd2, 4'd3, 8'd6, 0);

        begin
            int guard = 0;
            int target = in4 + 1000;
            while (in4 < target && guard < 30000) begin
                @(posedge clk); #1;
                bus4.in_valid  = ($urandom_range(0, 3) != 0);
                bus4.in_signed = 1'($urandom_range(0, 1));
                bus4.in_a      = 4'($urandom);
                bus4.in_b      = 4'($urandom);
                bus4.out_ready = ($urandom_range(0, 2) != 0);
                guard++;
            end
            check("rand4_count_reached", 32'(in4 >= target), 32'd1);
        end
        drain4();
        check("txn_count4", 32'(out4), 32'(in4));

        begin
            int guard = 0;
            while (!done8 && guard < 60000) begin
                @(posedge clk);
                guard++;
            end
        end
        check("rand8_finished", 32'(done8), 32'd1);
        check("rand8_count_reached", 32'(in8 >= 1000), 32'd1);
        check("txn_count8", 32'(out8), 32'(in8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
